// File: rtl/qspi_pkg.sv
// qspi_pkg: shared QSPI constants and the {be, data} read FIFO entry type.
package qspi_pkg;
  localparam logic [1:0] FMODE_IND_WR = 2'b00;
  localparam logic [1:0] FMODE_IND_RD = 2'b01;
  localparam int QSPI_BYTE_W = 8;
  localparam int QSPI_WORD_W = 32;
  typedef struct packed {
    logic [QSPI_WORD_W/QSPI_BYTE_W-1:0] be;
    logic [QSPI_WORD_W-1:0] data;
  } rd_entry_t;
endpackage

// File: rtl/qspi_sync_fifo.sv
// qspi_sync_fifo: single-clock FWFT FIFO with wrapping AW+1 bit pointers, full and level.
module qspi_sync_fifo #(
  parameter int AW = 3,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      lvl
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0] wptr, rptr;
  logic push_ok, pop_ok;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign lvl = wptr - rptr;
  assign pop_ok = pop && !empty;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign rdata = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wptr[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/qspi_rd_pack_fifo.sv
// qspi_rd_pack_fifo: packs QSPI read bytes little-endian into 32-bit words and buffers them.
// Optional level threshold flag enabled by QSPI_RD_FIFO_THRESH_EN.
module qspi_rd_pack_fifo
  import qspi_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          qspi_clk_i,
  input  logic          qspi_rst_i,
  input  logic          rd_fifo_clr_n_i,
  input  logic          rd_fifo_wrreq_n_i,
  input  logic [7:0]    rd_fifo_dat_i,
  input  logic          rd_flush_i,
  input  logic          rd_word_rdreq_i,
  output logic [31:0]   rd_word_dat_o,
  output logic [3:0]    rd_word_be_o,
  output logic          rd_word_vld_o,
  output logic          rd_fifo_full_o,
  output logic [AW:0]   rd_fifo_lvl_o,
  output logic          rd_ovf_o,
  input  logic [AW:0]   rd_thresh_i,
  output logic          rd_thresh_o
);
  logic clr, strobe, push, empty;
  logic [1:0] bi, nbi;
  logic [23:0] acc;
  logic [31:0] w;
  rd_entry_t wr_entry, head;
  assign clr = qspi_rst_i | ~rd_fifo_clr_n_i;
  assign strobe = ~rd_fifo_wrreq_n_i;
  assign nbi = bi + {1'b0, strobe};
  // the incoming byte is merged before any flush decision, so a completing byte yields one full push
  always_comb begin
    w = {8'h00, acc};
    if (strobe) w[{bi, 3'b000} +: 8] = rd_fifo_dat_i;
  end
  assign push = (strobe && bi == 2'd3) || (rd_flush_i && nbi != 2'd0);
  assign wr_entry = '{be: (strobe && bi == 2'd3) ? 4'hf : 4'((4'd1 << nbi) - 4'd1), data: w};
  always_ff @(posedge qspi_clk_i) begin
    if (clr) begin
      bi <= '0;
      acc <= '0;
      rd_ovf_o <= 1'b0;
    end else begin
      bi <= push ? 2'd0 : nbi;
      acc <= push ? 24'd0 : w[23:0];
      if (push && rd_fifo_full_o && !rd_word_rdreq_i) rd_ovf_o <= 1'b1;
    end
  end
  qspi_sync_fifo #(.AW(AW), .WIDTH($bits(rd_entry_t))) u_fifo (
    .clk(qspi_clk_i),
    .rst(clr),
    .push(push),
    .pop(rd_word_rdreq_i),
    .wdata(wr_entry),
    .rdata(head),
    .full(rd_fifo_full_o),
    .empty(empty),
    .lvl(rd_fifo_lvl_o)
  );
  assign rd_word_vld_o = ~empty;
  assign rd_word_dat_o = empty ? 32'h0 : head.data;
  assign rd_word_be_o = empty ? 4'h0 : head.be;
`ifdef QSPI_RD_FIFO_THRESH_EN
  always_ff @(posedge qspi_clk_i) begin
    if (qspi_rst_i) rd_thresh_o <= 1'b0;
    else rd_thresh_o <= rd_fifo_lvl_o >= rd_thresh_i;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^rd_thresh_i;
  assign rd_thresh_o = 1'b0;
`endif
endmodule
